// File: rtl/vga_axi_buffer_regs_slave.sv
// ============================================================================
// Module   : vga_axi_buffer_regs_slave
// Brief    : AXI4-Lite slave with four 32-bit control registers for the VGA
//            buffer datapath. Optional macro VGA_REGS_SLVERR_EN turns slots
//            4-7 into unmapped SLVERR slots; otherwise they alias slots 0-3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axi_buffer_regs_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
  output logic [3:0]                      reg_wr_pulse_o
);

  localparam logic [1:0] C_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;
  localparam int         C_NBYTES      = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [4];
  logic                          r_aw_held;
  logic [2:0]                    r_aw_slot;
  logic                          r_w_held;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata;
  logic [C_NBYTES-1:0]           r_wstrb;
  logic                          r_bvalid;
  logic [1:0]                    r_bresp;
  logic                          r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                    r_rresp;

  logic                          w_awready;
  logic                          w_wready;
  logic                          w_arready;
  logic                          w_aw_hs;
  logic                          w_w_hs;
  logic                          w_ar_hs;
  logic                          w_commit;
  logic [2:0]                    w_wslot;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_wdata;
  logic [C_NBYTES-1:0]           w_wstrb;
  logic                          w_wr_mapped;
  logic                          w_rd_mapped;
  logic [3:0]                    w_pulse;
  logic                          w_unused;

  assign w_awready = !r_aw_held && !r_bvalid;
  assign w_wready  = !r_w_held && !r_bvalid;
  assign w_arready = !r_rvalid;
  assign w_aw_hs   = S_AXI_AWVALID && w_awready;
  assign w_w_hs    = S_AXI_WVALID && w_wready;
  assign w_ar_hs   = S_AXI_ARVALID && w_arready;

  // Commit as soon as both halves exist, whether latched earlier or handshaking now.
  assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_wslot  = r_aw_held ? r_aw_slot : S_AXI_AWADDR[4:2];
  assign w_wdata  = r_w_held ? r_wdata : S_AXI_WDATA;
  assign w_wstrb  = r_w_held ? r_wstrb : S_AXI_WSTRB;

`ifdef VGA_REGS_SLVERR_EN
  assign w_wr_mapped = !w_wslot[2];
  assign w_rd_mapped = !S_AXI_ARADDR[4];
`else
  assign w_wr_mapped = 1'b1;
  assign w_rd_mapped = 1'b1;
`endif

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                      S_AXI_ARADDR[1:0], w_wslot[2], S_AXI_ARADDR[4]};

  always_comb begin
    w_pulse = 4'b0000;
    if (w_commit && w_wr_mapped && !S_AXI_ARESET) begin
      w_pulse[w_wslot[1:0]] = 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_aw_held <= 1'b0;
      r_aw_slot <= 3'd0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= C_RESP_OKAY;
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_slot <= S_AXI_AWADDR[4:2];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= S_AXI_WDATA;
        r_wstrb  <= S_AXI_WSTRB;
      end
      if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_mapped ? C_RESP_OKAY : C_RESP_SLVERR;
        if (w_wr_mapped) begin
          for (int b = 0; b < C_NBYTES; b++) begin
            if (w_wstrb[b]) begin
              r_regs[w_wslot[1:0]][b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Read data samples the pre-commit register values, so a same-cycle write stays invisible.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= C_RESP_OKAY;
    end else begin
      if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_mapped ? r_regs[S_AXI_ARADDR[3:2]] : '0;
        r_rresp  <= w_rd_mapped ? C_RESP_OKAY : C_RESP_SLVERR;
      end
    end
  end

  assign S_AXI_AWREADY  = w_awready;
  assign S_AXI_WREADY   = w_wready;
  assign S_AXI_ARREADY  = w_arready;
  assign S_AXI_BVALID   = r_bvalid;
  assign S_AXI_BRESP    = r_bresp;
  assign S_AXI_RVALID   = r_rvalid;
  assign S_AXI_RDATA    = r_rdata;
  assign S_AXI_RRESP    = r_rresp;
  assign reg0_o         = r_regs[0];
  assign reg1_o         = r_regs[1];
  assign reg2_o         = r_regs[2];
  assign reg3_o         = r_regs[3];
  assign reg_wr_pulse_o = w_pulse;

endmodule

`default_nettype wire

// File: tb/tb_vga_axi_buffer_regs_slave.sv
// ============================================================================
// Module   : tb_vga_axi_buffer_regs_slave
// Brief    : Self-checking bench for vga_axi_buffer_regs_slave (table vectors,
//            directed corner sequences, random traffic vs. a register model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_axi_buffer_regs_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [4:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  pulse;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [4];

  vga_axi_buffer_regs_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg0_o        (reg0),
    .reg1_o        (reg1),
    .reg2_o        (reg2),
    .reg3_o        (reg3),
    .reg_wr_pulse_o(pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit is_mapped(input logic [4:0] a);
`ifdef VGA_REGS_SLVERR_EN
    return (a < 5'h10);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int slot_of(input logic [4:0] a);
    return int'(a / 4) % 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    return is_mapped(a) ? model[slot_of(a)] : 32'h0;
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    if (is_mapped(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model[slot_of(a)][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_reg0"}, reg0, model[0]);
    check({tag, "_reg1"}, reg1, model[1]);
    check({tag, "_reg2"}, reg2, model[2]);
    check({tag, "_reg3"}, reg3, model[3]);
  endtask

  // Entered and left at posedge+1; outputs sampled at negedge.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_wait);
    bit aw_done, w_done, committed, aw_hs, w_hs;
    logic [1:0] eresp;
    logic [3:0] epulse;
    aw_done = 0; w_done = 0; committed = 0;
    eresp  = is_mapped(a) ? 2'b00 : 2'b10;
    epulse = is_mapped(a) ? (4'b0001 << slot_of(a)) : 4'b0000;
    awaddr = a; wdata = d; wstrb = s;
    for (int cyc = 0; cyc < 30 && !committed; cyc++) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      @(negedge clk);
      if (w_done && !aw_done) check("wready_low_after_w", wready, 0);
      if (aw_done && !w_done) check("awready_low_after_aw", awready, 0);
      check("bvalid_before_commit", bvalid, 0);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
      committed = aw_done && w_done;
      check("wr_pulse", pulse, committed ? epulse : 4'b0000);
      @(posedge clk); #1;
    end
    awvalid = 0; wvalid = 0;
    if (!committed) begin
      checks++; errors++;
      $display("FAIL write_timeout actual=no_commit required=commit");
      return;
    end
    model_write(a, d, s);
    for (int i = 0; i < b_wait; i++) begin
      @(negedge clk);
      check("bvalid_hold", bvalid, 1);
      check("bresp_hold", bresp, eresp);
      check("awready_while_b", awready, 0);
      check("wready_while_b", wready, 0);
      check("pulse_while_b", pulse, 0);
      @(posedge clk); #1;
    end
    bready = 1;
    @(negedge clk);
    check("bvalid", bvalid, 1);
    check("bresp", bresp, eresp);
    check("pulse_after_commit", pulse, 0);
    @(posedge clk); #1;
    bready = 0;
    @(negedge clk);
    check("bvalid_cleared", bvalid, 0);
    check("awready_after_b", awready, 1);
    check("wready_after_b", wready, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [4:0] a, input int r_wait, output logic [31:0] got);
    bit hs;
    logic [31:0] edata;
    logic [1:0]  eresp;
    hs = 0;
    edata = model_read(a);
    eresp = is_mapped(a) ? 2'b00 : 2'b10;
    araddr = a;
    arvalid = 1;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk); #1;
    end
    arvalid = 0;
    got = rdata;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL read_timeout actual=no_arready required=arready");
      return;
    end
    for (int i = 0; i < r_wait; i++) begin
      @(negedge clk);
      check("rvalid_hold", rvalid, 1);
      check("rdata_hold", rdata, edata);
      check("arready_while_r", arready, 0);
      @(posedge clk); #1;
    end
    rready = 1;
    @(negedge clk);
    check("rvalid", rvalid, 1);
    check("rdata", rdata, edata);
    check("rresp", rresp, eresp);
    got = rdata;
    @(posedge clk); #1;
    rready = 0;
    @(negedge clk);
    check("rvalid_cleared", rvalid, 0);
    check("arready_after_r", arready, 1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_read;
  } vec_t;

  initial begin
    vec_t vecs [5];
    logic [31:0] rd;
    vecs[0] = '{5'h00, 32'h0101FFFF, 4'hF, 32'h0101FFFF};
    vecs[1] = '{5'h04, 32'hABCD0001, 4'hF, 32'hABCD0001};
    vecs[2] = '{5'h08, 32'hDEAD0011, 4'hF, 32'hDEAD0011};
    vecs[3] = '{5'h0C, 32'hBEEF0011, 4'hF, 32'hBEEF0011};
    vecs[4] = '{5'h08, 32'h12345678, 4'h3, 32'hDEAD5678};
    for (int i = 0; i < 4; i++) model[i] = 32'h0;

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_awready", awready, 1);
    check("rst_wready", wready, 1);
    check("rst_arready", arready, 1);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_pulse", pulse, 0);
    check_regs("rst");
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0);
      do_read(vecs[i].addr, 0, rd);
      check("tbl_readback", rd, vecs[i].exp_read);
      check_regs("tbl");
    end

    // W presented three cycles ahead of AW.
    do_write(5'h04, 32'hCAFEF00D, 4'hF, 3, 0, 0);
    check_regs("split");
    do_write(5'h00, 32'h5A5A5A5A, 4'hA, 0, 2, 0);
    check_regs("split2");

    // Response backpressure.
    do_write(5'h0C, 32'h87654321, 4'hF, 0, 0, 5);
    do_read(5'h0C, 5, rd);
    check("bp_readback", rd, 32'h87654321);

    // Strobe of zero still pulses but leaves data intact.
    do_write(5'h04, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
    check_regs("strb0");

    // Reset with AW latched and W outstanding.
    awaddr = 5'h04; awvalid = 1;
    @(negedge clk);
    check("rst_mid_awready", awready, 1);
    @(posedge clk); #1;
    awvalid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_bvalid", bvalid, 0);
      check("rst_mid_wready", wready, 1);
      @(posedge clk); #1;
    end
    check_regs("rst_mid");
    for (int i = 0; i < 4; i++) begin
      do_read(5'(i * 4), 0, rd);
      check("rst_mid_read", rd, 0);
    end
    do_write(5'h04, 32'h13579BDF, 4'hF, 0, 0, 0);
    do_read(5'h04, 0, rd);
    check("rst_fresh_write", rd, 32'h13579BDF);

    // Upper slot: SLVERR when enabled, alias of reg0 otherwise.
    do_write(5'h00, 32'h00C0FFEE, 4'hF, 0, 0, 0);
    do_write(5'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_read(5'h10, 0, rd);
    do_read(5'h00, 0, rd);
`ifdef VGA_REGS_SLVERR_EN
    check("hi_slot_reg0", rd, 32'h00C0FFEE);
`else
    check("hi_slot_reg0", rd, 32'hFFFFFFFF);
`endif
    check_regs("hi_slot");

    for (int n = 0; n < 60; n++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end else begin
        do_read(a, $urandom_range(0, 2), rd);
      end
    end
    check_regs("rand_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_axi_buffer_regs_slave.md
# vga_axi_buffer_regs_slave

AXI4-Lite slave register file for the VGA AXI buffer IP: the responder end of the PS/BFM master's single-beat write and read transactions. Holds four 32-bit control registers at byte offsets 0x0, 0x4, 0x8 and 0xC, with byte-strobe writes and read-back. Drives the register values and per-register write pulses into the VGA buffer datapath on the same clock.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; bits [4:2] select the word slot, bits [1:0] are ignored.
- S_AXI_ACLK  in  1  single clock for all logic.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
- reg0_o, reg1_o, reg2_o, reg3_o  out  32 each  current register contents.
- reg_wr_pulse_o  out  4  one-cycle pulse, one bit per register, asserted on commit.

## Operation
- Write channel:
  - AW and W are accepted independently and in either order.
  - S_AXI_AWREADY = !aw_held && !S_AXI_BVALID. S_AXI_WREADY = !w_held && !S_AXI_BVALID.
  - A handshaked address is latched and sets aw_held. A handshaked data beat (data and strobe) is latched and sets w_held.
- Commit:
  - Occurs in the cycle where the address is present (held or handshaking) and the data is present (held or handshaking).
  - Each byte with WSTRB[i]=1 is written; bytes with WSTRB[i]=0 keep their value.
  - The matching reg_wr_pulse_o bit goes high for that cycle, including when WSTRB=0.
  - aw_held and w_held clear. S_AXI_BVALID is set with BRESP=OKAY.
- Response hold: BVALID, BRESP, RVALID, RDATA and RRESP stay stable until their READY is seen; VALID then deasserts.
- Read channel:
  - S_AXI_ARREADY = !S_AXI_RVALID.
  - On AR handshake, data is captured from the register contents as of that cycle. A write committing in the same cycle is not visible to that read.
  - RRESP = OKAY.
- Channel independence: read and write channels operate concurrently with no mutual blocking.
- Slot decode: slots 0-3 map to reg0-reg3. Slots 4-7 are handled as defined under Configuration.

## Timing
- Reset values (cycle after S_AXI_ARESET is sampled high): all registers 0x00000000; BVALID, RVALID and reg_wr_pulse_o = 0; AWREADY, WREADY and ARREADY = 1; RDATA = 0; BRESP and RRESP = 00; held flags cleared.
- Write: AW and W handshake together in cycle N → register updated and pulse high in N; new value on regX_o in N+1; BVALID high in N+1.
- Write, split: if the later of AW/W handshakes in cycle M, commit happens in M with the same N+1 rules.
- Back-to-back writes: B handshake in cycle K → AWREADY and WREADY high in K+1. Maximum rate is one write per 2 cycles.
- Read: AR handshake in cycle N → RVALID and RDATA in N+1. ARREADY low while RVALID is high. Maximum rate is one read per 2 cycles.
- Reset mid-transaction: held AW/W are discarded, pending B/R are dropped with no response, and registers return to 0.

## Configuration
- VGA_REGS_SLVERR_EN defined: slots 4-7 are unmapped.
  - Writes are accepted, modify nothing, produce no pulse, and return BRESP=SLVERR (10).
  - Reads return RDATA=0 with RRESP=SLVERR.
- VGA_REGS_SLVERR_EN undefined: only addr[3:2] is decoded. Slots 4-7 alias slots 0-3, and all responses are OKAY.

## Test plan
- Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0, 0x4, 0x8, 0xC, each followed by a read of the same address → every BRESP/RRESP is OKAY, each read returns the written word, regX_o match, and each reg_wr_pulse_o bit pulses exactly once.
- Write 0x12345678 to 0x8 with WSTRB=0011 after 0xDEAD0011 → readback is 0xDEAD5678.
- Present WVALID 3 cycles before AWVALID → WREADY drops after the W handshake, commit occurs on the AW handshake cycle, and BVALID rises on the next cycle.
- Hold BREADY low for 5 cycles after a write, and hold RREADY low for 5 cycles after a read → BVALID/BRESP and RVALID/RDATA stay stable, and AWREADY, WREADY and ARREADY stay low until the respective handshake.
- Assert S_AXI_ARESET with AW held and W not yet sent → BVALID never rises, all registers read 0x0, and a fresh write to 0x4 then completes normally.
- With VGA_REGS_SLVERR_EN defined, write 0xFFFFFFFF to 0x10, then read 0x10 and 0x0 → the write returns BRESP=10, the 0x10 read returns RRESP=10 with RDATA=0, and 0x0 is unchanged. Without the macro, the 0x10 write lands in reg0.
